// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Boot-time program loader. Takes a byte stream over valid/ready,
//             reads a 16-bit little-endian word count, then assembles that
//             many little-endian 32-bit words and writes them into the
//             instruction memory at word addresses 0..N-1. The CPU is kept
//             in reset until every word has been written.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32   // word width; the assembly path is 4 bytes wide
) (
  input  logic              clk,
  input  logic              rst,         // synchronous, active-low
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              cpu_rst,     // active-high CPU reset
  output logic              done,
  output logic              error
);

  // Memory depth in 17 bits so the N > DEPTH test cannot overflow for any
  // 16-bit header value, including ADDR_W = 16.
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [15:0]         count, count_nxt;      // word count N from the header
  logic [15:0]         widx, widx_nxt;        // index of the word being built
  logic [1:0]          bidx, bidx_nxt;        // byte position within the word
  logic [23:0]         part, part_nxt;        // bytes 0..2 of the current word
  logic                ready_nxt;
  logic                we_nxt;
  logic [ADDR_W-1:0]   waddr_nxt;
  logic [XLEN-1:0]     wdata_nxt;
  logic                cpu_rst_nxt;
  logic                done_nxt;
  logic                error_nxt;
  logic                accept;
  logic [15:0]         hdr_n;

  assign accept = byte_valid & byte_ready;
  assign hdr_n  = {byte_data, count[7:0]};

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    widx_nxt    = widx;
    bidx_nxt    = bidx;
    part_nxt    = part;
    we_nxt      = 1'b0;
    waddr_nxt   = imem_waddr;
    wdata_nxt   = imem_wdata;
    cpu_rst_nxt = cpu_rst;
    done_nxt    = done;
    error_nxt   = error;

    case (state)
      HDR0: begin
        if (accept) begin
          count_nxt[7:0] = byte_data;
          state_nxt      = HDR1;
        end
      end

      HDR1: begin
        if (accept) begin
          count_nxt = hdr_n;
          if (hdr_n == 16'd0 || {1'b0, hdr_n} > DEPTH) begin
            state_nxt = ERR;
            error_nxt = 1'b1;
          end else begin
            state_nxt = DATA;
            widx_nxt  = 16'd0;
            bidx_nxt  = 2'd0;
          end
        end
      end

      DATA: begin
        if (accept) begin
          if (bidx == 2'd3) begin
            // Fourth byte: the word is complete, issue the write pulse.
            we_nxt    = 1'b1;
            waddr_nxt = widx[ADDR_W-1:0];
            wdata_nxt = {byte_data, part};
            widx_nxt  = widx + 16'd1;
            bidx_nxt  = 2'd0;
            if (widx == count - 16'd1) begin
              state_nxt = DONE;
            end
          end else begin
            // Shift in from the top so byte 0 ends up in bits [7:0].
            part_nxt = {byte_data, part[23:8]};
            bidx_nxt = bidx + 2'd1;
          end
        end
      end

      DONE: begin
        if (reload) begin
          state_nxt   = HDR0;
          cpu_rst_nxt = 1'b1;
          done_nxt    = 1'b0;
          count_nxt   = 16'd0;
          widx_nxt    = 16'd0;
          bidx_nxt    = 2'd0;
          part_nxt    = 24'd0;
        end else begin
          cpu_rst_nxt = 1'b0;
          done_nxt    = 1'b1;
        end
      end

      ERR: begin
        if (reload) begin
          state_nxt = HDR0;
          error_nxt = 1'b0;
          count_nxt = 16'd0;
          widx_nxt  = 16'd0;
          bidx_nxt  = 2'd0;
          part_nxt  = 24'd0;
        end
      end

      default: begin
        state_nxt = HDR0;
      end
    endcase

    ready_nxt = (state_nxt == HDR0) || (state_nxt == HDR1) || (state_nxt == DATA);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= HDR0;
      count      <= 16'd0;
      widx       <= 16'd0;
      bidx       <= 2'd0;
      part       <= 24'd0;
      byte_ready <= 1'b1;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      widx       <= widx_nxt;
      bidx       <= bidx_nxt;
      part       <= part_nxt;
      byte_ready <= ready_nxt;
      imem_we    <= we_nxt;
      imem_waddr <= waddr_nxt;
      imem_wdata <= wdata_nxt;
      cpu_rst    <= cpu_rst_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. Byte streams are built
//             from random or fixed words; a reference model decodes each
//             stream into the list of (address, word) writes it must cause.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              reload = 1'b0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: logs every write pulse and flags back-to-back pulses or
  // writes while the CPU is already released.
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic        prev_we  = 1'b0;
  int          overlap  = 0;
  int          bad_rst  = 0;
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(32'(imem_waddr));
      got_data.push_back(imem_wdata);
      if (prev_we) overlap++;
      if (cpu_rst !== 1'b1) bad_rst++;
    end
    prev_we = (imem_we === 1'b1);
  end

  // Reference model: decode a byte stream into the writes it must produce.
  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_err;

  function automatic void model();
    int n;
    exp_addr.delete();
    exp_data.delete();
    n = int'(stream[0]) + 256 * int'(stream[1]);
    exp_err = (n == 0) || (n > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(32'(i % DEPTH));
        exp_data.push_back({stream[2+4*i+3], stream[2+4*i+2],
                            stream[2+4*i+1], stream[2+4*i]});
      end
    end
  endfunction

  task automatic put_header(input int n);
    stream.delete();
    stream.push_back(8'(n & 255));
    stream.push_back(8'((n >> 8) & 255));
  endtask

  task automatic put_word(input logic [31:0] w);
    stream.push_back(w[7:0]);
    stream.push_back(w[15:8]);
    stream.push_back(w[23:16]);
    stream.push_back(w[31:24]);
  endtask

  task automatic make_random(input int n);
    put_header(n);
    for (int i = 0; i < n; i++) put_word($urandom);
  endtask

  // Offer one byte after 0..maxgap idle cycles; returns at posedge+1 after
  // the accepting edge. Starts and ends at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int  gap;
    bit  ok;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_reload(input bit with_byte);
    reload     = 1'b1;
    byte_valid = with_byte;
    byte_data  = 8'($urandom);
    @(posedge clk); #1;
    reload     = 1'b0;
    byte_valid = 1'b0;
  endtask

  // Reload from DONE/ERR and confirm the loader is back in its idle header state.
  task automatic do_reload(input bit with_byte);
    pulse_reload(with_byte);
    @(negedge clk);
    check("rl_ready",   32'(byte_ready), 32'd1);
    check("rl_cpu_rst", 32'(cpu_rst),    32'd1);
    check("rl_done",    32'(done),       32'd0);
    check("rl_error",   32'(error),      32'd0);
    @(posedge clk); #1;
  endtask

  // Send the current stream and compare the resulting writes and flags.
  // reload_at >= 0 pulses reload before that byte index (must be ignored).
  task automatic run_load(input int maxgap, input int reload_at);
    int base;
    int n;
    base = got_addr.size();
    model();
    for (int i = 0; i < stream.size(); i++) begin
      if (i == reload_at) pulse_reload(1'b0);
      send_byte(stream[i], maxgap);
    end
    if (exp_err) begin
      @(negedge clk);
      check("err_flag",    32'(error),      32'd1);
      check("err_ready",   32'(byte_ready), 32'd0);
      check("err_cpu_rst", 32'(cpu_rst),    32'd1);
      check("err_done",    32'(done),       32'd0);
    end else begin
      @(negedge clk);
      check("last_we",      32'(imem_we), 32'd1);
      check("done_early",   32'(done),    32'd0);
      check("cpu_rst_held", 32'(cpu_rst), 32'd1);
      @(negedge clk);
      check("done",         32'(done),       32'd1);
      check("cpu_rst_rel",  32'(cpu_rst),    32'd0);
      check("we_single",    32'(imem_we),    32'd0);
      check("done_ready",   32'(byte_ready), 32'd0);
    end
    @(posedge clk); #1;
    check("n_writes", 32'(got_addr.size() - base), 32'(exp_addr.size()));
    n = got_addr.size() - base;
    if (n > exp_addr.size()) n = exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("waddr[%0d]", i), got_addr[base+i], exp_addr[i]);
      check($sformatf("wdata[%0d]", i), got_data[base+i], exp_data[i]);
    end
  endtask

  // Hold byte_valid for a few cycles in DONE/ERR; nothing may be written.
  task automatic offer_idle(input string tag);
    int base;
    base = got_addr.size();
    repeat (3) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clk);
      check({tag, "_ready"}, 32'(byte_ready), 32'd0);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_nowrite"}, 32'(got_addr.size() - base), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    logic [31:0] w0;

    // Reset state.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready",   32'(byte_ready), 32'd1);
    check("rst_we",      32'(imem_we),    32'd0);
    check("rst_waddr",   32'(imem_waddr), 32'd0);
    check("rst_wdata",   imem_wdata,      32'd0);
    check("rst_cpu_rst", 32'(cpu_rst),    32'd1);
    check("rst_done",    32'(done),       32'd0);
    check("rst_error",   32'(error),      32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Three-word program, continuous valid.
    put_header(3);
    put_word(32'h00500093);
    put_word(32'h00A00113);
    put_word(32'h002081B3);
    run_load(0, -1);
    offer_idle("done_idle");
    do_reload(1'b1);

    // Same program with random gaps in byte_valid.
    put_header(3);
    put_word(32'h00500093);
    put_word(32'h00A00113);
    put_word(32'h002081B3);
    run_load(3, -1);
    do_reload(1'b0);

    // Random programs with an ignored reload pulse somewhere mid-stream.
    for (int k = 0; k < 5; k++) begin
      make_random(int'($urandom_range(6, 1)));
      run_load(int'($urandom_range(2, 0)), int'($urandom_range(stream.size() - 1, 0)));
      do_reload(1'(k & 1));
    end

    // Rejected word counts.
    put_header(0);
    run_load(1, -1);
    offer_idle("err0_idle");
    do_reload(1'b0);
    put_header(DEPTH + 1);
    run_load(0, -1);
    offer_idle("err257_idle");
    do_reload(1'b1);
    put_header(int'($urandom_range(65535, DEPTH + 2)));
    run_load(0, -1);
    do_reload(1'b0);

    // Full depth: every address written, last one all ones.
    make_random(DEPTH);
    run_load(0, -1);
    check("last_waddr", got_addr[got_addr.size()-1], 32'(DEPTH - 1));
    do_reload(1'b0);

    // Reset in the middle of word 1.
    make_random(3);
    w0 = {stream[5], stream[4], stream[3], stream[2]};
    base = got_addr.size();
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready",   32'(byte_ready), 32'd1);
    check("mid_rst_cpu_rst", 32'(cpu_rst),    32'd1);
    check("mid_rst_done",    32'(done),       32'd0);
    check("mid_rst_we",      32'(imem_we),    32'd0);
    @(posedge clk); #1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_rst_writes", 32'(got_addr.size() - base), 32'd1);
    check("mid_rst_w0addr", got_addr[base], 32'd0);
    check("mid_rst_w0data", got_data[base], w0);
    put_header(1);
    put_word($urandom);
    run_load(1, -1);

    // Reload after a completed load, then a one-word program.
    offer_idle("done2_idle");
    do_reload(1'b1);
    put_header(1);
    put_word(32'h00000013);
    run_load(0, -1);

    check("no_overlap",   32'(overlap), 32'd0);
    check("we_in_reset",  32'(bad_rst), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the RISC-V CPU.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory's write port.
- Holds the CPU in reset (active-high `cpu_rst`, the CPU's reset convention) until the whole program is loaded, then releases it so execution starts at word address 0.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- XLEN, 32, word width; fixed at 32, 4 bytes per word.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on the rising edge of clk).
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to start a new load; honoured only in DONE or ERR.
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse.
- imem_waddr  output  ADDR_W  word address.
- imem_wdata  output  32  word data.
- cpu_rst  output  1  CPU reset, active-high.
- done  output  1  load completed successfully.
- error  output  1  header rejected.

Behaviour:
- All outputs are registered.
- Reset values (rst=0 at an edge):
  - state=HDR0, byte_ready=1, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_rst=1, done=0, error=0.
  - Internal word counter, byte index and partial word are cleared.
  - Instruction-memory contents are not touched.
- Handshake: a byte is accepted on an edge where byte_valid=1 and byte_ready=1.
  - byte_ready=1 in HDR0, HDR1 and DATA; 0 in DONE and ERR.
  - byte_data is ignored when not accepted.
  - Gaps in byte_valid of any length are allowed.
- Stream format:
  - 16-bit little-endian word count N (HDR0 = low byte, HDR1 = high byte).
  - Followed by N*4 data bytes; each word is little-endian, first byte = bits [7:0].
- States and transitions:
  - HDR0: accept → latch N[7:0], go to HDR1.
  - HDR1: accept → latch N[15:8]; if N==0 or N>DEPTH go to ERR (error<=1), else go to DATA with word index 0 and byte index 0.
  - DATA: each accept shifts the byte into the partial word and increments the 2-bit byte index.
    - On the 4th byte, at the same edge: imem_we<=1, imem_waddr<=word index, imem_wdata<=assembled word, word index+1, byte index wraps to 0.
    - If that was word N-1, go to DONE.
  - DONE: at the edge after the final imem_we pulse, cpu_rst<=0 and done<=1.
    - reload=1 → HDR0 with cpu_rst<=1, done<=0, counters cleared.
  - ERR: cpu_rst held 1, error held 1, all bytes refused.
    - reload=1 → HDR0 with error<=0.
- Latency:
  - imem_we is asserted for exactly one cycle, in the cycle after the 4th byte is accepted.
  - done and cpu_rst deassertion are visible one cycle after the final write pulse.
  - imem_we is 0 in every other cycle.
- Throughput: one byte per cycle sustained, so at most one write every 4 cycles; writes never overlap.
- Address arithmetic:
  - imem_waddr is the word index truncated to ADDR_W bits.
  - N==DEPTH is legal and writes addresses 0..DEPTH-1; the last address is all ones.
  - N>DEPTH is rejected before any write occurs.
- Boundary conditions:
  - reload outside DONE/ERR is ignored.
  - reload asserted together with byte_valid in DONE: the byte is not accepted (byte_ready=0 that cycle).
  - Reset mid-load: the partial word is discarded, no write pulse is produced, cpu_rst stays 1, and the loader restarts in HDR0.
  - Reset has priority over reload and over byte acceptance.

Test Plan:
- Load three words with continuous valid: N=0x0003, words 0x00500093, 0x00A00113, 0x002081B3 sent as 12 little-endian bytes → imem_we pulses at addresses 0, 1, 2 carrying exactly those values. The following cycle cpu_rst=0 and done=1; the CPU then executes and its Result shows 5, 10, 15.
- Same stream with random 0–3 cycle gaps in byte_valid → identical writes and final state. No write is produced while byte_valid=0 mid-word.
- Rejected counts: N=0x0000 → error=1 after the 2nd byte. N=DEPTH+1 (0x0101 with ADDR_W=8) → error=1. In both cases no imem_we pulse, cpu_rst=1 and byte_ready=0.
- Full depth: N=256 with ADDR_W=8 → 256 writes, last at waddr=0xFF. done=1 and no address wrap-around write.
- Reset mid-word: rst=0 after 2 of the 4 bytes of word 1 → no write for word 1, state HDR0, cpu_rst=1. A fresh N=1 load then writes address 0.
- Reload: after a completed load, pulse reload → cpu_rst=1, done=0, byte_ready=1. Bytes offered in DONE before reload are not accepted; a second load of N=1, 0x00000013 writes address 0.
